// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one I2C write engine.
// Grants, launches, times out and reports status per transaction.
module i2c_master_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 256,
  parameter int BUF_CYC     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              resp_nack,
  output logic              resp_timeout,
  output logic              busy,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_data,
  output logic              m_abort,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int GW = (BUF_CYC > 1) ? $clog2(BUF_CYC) : 1;
  localparam logic [IW:0]   NR   = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST = IW'(NREQ-1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC-1);
  localparam logic [GW-1:0] GMAX = GW'(BUF_CYC-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_win;
  logic [TW-1:0]   r_timer;
  logic [GW-1:0]   r_gap;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_nack;
  logic            r_to;
  logic            r_busy;
  logic            r_start;
  logic            r_abort;
  logic [6:0]      r_addr;
  logic [7:0]      r_data;

  logic [IW:0]     w_pos;
  logic [IW-1:0]   w_pick;
  logic [IW-1:0]   w_nptr;
  logic [NREQ-1:0] w_oh;
  logic [6:0]      w_addr;
  logic [7:0]      w_data;

  // First requester at or above the pointer, wrapping; descending
  // scan so the nearest candidate is the last one written.
  always_comb begin
    w_pos  = '0;
    w_pick = '0;
    for (int i = NREQ-1; i >= 0; i--) begin
      w_pos = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_pos >= NR) w_pos = w_pos - NR;
      if (req[w_pos[IW-1:0]]) w_pick = w_pos[IW-1:0];
    end
  end

  // Winner's address/data, one-hot grant and next pointer value.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == IW'(i)) begin
        w_addr = req_addr[7*i +: 7];
        w_data = req_data[8*i +: 8];
      end
    end
    w_oh   = NREQ'(1) << w_pick;
    w_nptr = (r_win == LAST) ? '0 : r_win + IW'(1);
  end

  // Sequencer: grant, launch, wait with timeout, report, bus gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_timer <= '0;
      r_gap   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_nack  <= 1'b0;
      r_to    <= 1'b0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|req && !m_busy) begin
            r_win   <= w_pick;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_gnt   <= w_oh;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_start <= 1'b0;
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (m_done) begin
            r_nack  <= m_nack;
            r_to    <= 1'b0;
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_state <= S_DONE;
          end else if (r_timer == TMAX) begin
            r_nack  <= 1'b0;
            r_to    <= 1'b1;
            r_abort <= 1'b1;
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_state <= S_DONE;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_nack  <= 1'b0;
          r_to    <= 1'b0;
          r_abort <= 1'b0;
          r_ptr   <= w_nptr;
          r_gap   <= '0;
          if (BUF_CYC > 0) begin
            r_state <= S_GAP;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap == GMAX) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign done         = r_done;
  assign resp_nack    = r_nack;
  assign resp_timeout = r_to;
  assign busy         = r_busy;
  assign m_start      = r_start;
  assign m_addr       = r_addr;
  assign m_data       = r_data;
  assign m_abort      = r_abort;

endmodule
